// File: rtl/uart_cmd_pkg.sv
// Shared command map for the UART ASCII decoder: the 14 command byte codes
// and the bit positions of the 14-bit pulse vector
// {C,U,D,L,R,Sw0,Sw1,Sw2,Sw3,Clr,Watch,Sr04,Temp,Hum} (C is the MSB).
package uart_cmd_pkg;

    localparam int CMD_COUNT = 14;

    // ASCII command codes (case-sensitive)
    localparam logic [7:0] CMD_BTN_C   = 8'h63; // 'c'
    localparam logic [7:0] CMD_BTN_U   = 8'h75; // 'u'
    localparam logic [7:0] CMD_BTN_D   = 8'h64; // 'd'
    localparam logic [7:0] CMD_BTN_L   = 8'h6C; // 'l'
    localparam logic [7:0] CMD_BTN_R   = 8'h72; // 'r'
    localparam logic [7:0] CMD_TGL_SW0 = 8'h31; // '1'
    localparam logic [7:0] CMD_TGL_SW1 = 8'h33; // '3'
    localparam logic [7:0] CMD_TGL_SW2 = 8'h35; // '5'
    localparam logic [7:0] CMD_TGL_SW3 = 8'h36; // '6'
    localparam logic [7:0] CMD_CLR_TGL = 8'h78; // 'x'
    localparam logic [7:0] CMD_RPT_WCH = 8'h77; // 'w'
    localparam logic [7:0] CMD_RPT_SR4 = 8'h73; // 's'
    localparam logic [7:0] CMD_RPT_TMP = 8'h74; // 't'
    localparam logic [7:0] CMD_RPT_HUM = 8'h68; // 'h'

    // Bit positions inside the pulse vector
    localparam int BIT_BTN_C   = 13;
    localparam int BIT_BTN_U   = 12;
    localparam int BIT_BTN_D   = 11;
    localparam int BIT_BTN_L   = 10;
    localparam int BIT_BTN_R   = 9;
    localparam int BIT_TGL_SW0 = 8;
    localparam int BIT_TGL_SW1 = 7;
    localparam int BIT_TGL_SW2 = 6;
    localparam int BIT_TGL_SW3 = 5;
    localparam int BIT_CLR_TGL = 4;
    localparam int BIT_RPT_WCH = 3;
    localparam int BIT_RPT_SR4 = 2;
    localparam int BIT_RPT_TMP = 1;
    localparam int BIT_RPT_HUM = 0;

endpackage

// File: rtl/uart_ascii_decoder.sv
// Decodes each received UART byte into a one-cycle command pulse and echoes
// every byte on the loopback channel. One register stage, no other state.
// Handshake: iRxValid is a pure strobe (no ready); every cycle it is high is
// one byte, and oLoopValid/pulses are strobes valid for exactly one cycle.
module uart_ascii_decoder
    import uart_cmd_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iRxData,
    input  logic       iRxValid,
    output logic       oBtnC,
    output logic       oBtnU,
    output logic       oBtnD,
    output logic       oBtnL,
    output logic       oBtnR,
    output logic       oTglSw0,
    output logic       oTglSw1,
    output logic       oTglSw2,
    output logic       oTglSw3,
    output logic       oClrSwTgl,
    output logic       oReqWatchRpt,
    output logic       oReqSr04Rpt,
    output logic       oReqTempRpt,
    output logic       oReqHumRpt,
    output logic [7:0] oLoopData,
    output logic       oLoopValid
);

    logic [CMD_COUNT-1:0] w_pulse;
    logic [CMD_COUNT-1:0] r_pulse;
    logic [7:0]           r_loop_data;
    logic                 r_loop_valid;

    // Combinational one-hot decode of the incoming byte, gated by the strobe
    always_comb begin
        w_pulse = '0;
        if (iRxValid) begin
            case (iRxData)
                CMD_BTN_C:   w_pulse[BIT_BTN_C]   = 1'b1;
                CMD_BTN_U:   w_pulse[BIT_BTN_U]   = 1'b1;
                CMD_BTN_D:   w_pulse[BIT_BTN_D]   = 1'b1;
                CMD_BTN_L:   w_pulse[BIT_BTN_L]   = 1'b1;
                CMD_BTN_R:   w_pulse[BIT_BTN_R]   = 1'b1;
                CMD_TGL_SW0: w_pulse[BIT_TGL_SW0] = 1'b1;
                CMD_TGL_SW1: w_pulse[BIT_TGL_SW1] = 1'b1;
                CMD_TGL_SW2: w_pulse[BIT_TGL_SW2] = 1'b1;
                CMD_TGL_SW3: w_pulse[BIT_TGL_SW3] = 1'b1;
                CMD_CLR_TGL: w_pulse[BIT_CLR_TGL] = 1'b1;
                CMD_RPT_WCH: w_pulse[BIT_RPT_WCH] = 1'b1;
                CMD_RPT_SR4: w_pulse[BIT_RPT_SR4] = 1'b1;
                CMD_RPT_TMP: w_pulse[BIT_RPT_TMP] = 1'b1;
                CMD_RPT_HUM: w_pulse[BIT_RPT_HUM] = 1'b1;
                default:     w_pulse = '0;
            endcase
        end
    end

    // Output register stage; echo data holds its last value between bytes
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_pulse      <= '0;
            r_loop_data  <= 8'h00;
            r_loop_valid <= 1'b0;
        end else begin
            r_pulse      <= w_pulse;
            r_loop_valid <= iRxValid;
            if (iRxValid) begin
                r_loop_data <= iRxData;
            end
        end
    end

    assign oBtnC        = r_pulse[BIT_BTN_C];
    assign oBtnU        = r_pulse[BIT_BTN_U];
    assign oBtnD        = r_pulse[BIT_BTN_D];
    assign oBtnL        = r_pulse[BIT_BTN_L];
    assign oBtnR        = r_pulse[BIT_BTN_R];
    assign oTglSw0      = r_pulse[BIT_TGL_SW0];
    assign oTglSw1      = r_pulse[BIT_TGL_SW1];
    assign oTglSw2      = r_pulse[BIT_TGL_SW2];
    assign oTglSw3      = r_pulse[BIT_TGL_SW3];
    assign oClrSwTgl    = r_pulse[BIT_CLR_TGL];
    assign oReqWatchRpt = r_pulse[BIT_RPT_WCH];
    assign oReqSr04Rpt  = r_pulse[BIT_RPT_SR4];
    assign oReqTempRpt  = r_pulse[BIT_RPT_TMP];
    assign oReqHumRpt   = r_pulse[BIT_RPT_HUM];
    assign oLoopData    = r_loop_data;
    assign oLoopValid   = r_loop_valid;

endmodule

// File: tb/tb_uart_ascii_decoder.sv
// Bench for uart_ascii_decoder: directed command sweep, non-command bytes,
// randomized byte streams against a lookup-table reference model, and an
// asynchronous reset applied in the middle of a pulse.
module tb_uart_ascii_decoder;

    logic       iClk;
    logic       iRst;
    logic [7:0] iRxData;
    logic       iRxValid;
    logic       oBtnC, oBtnU, oBtnD, oBtnL, oBtnR;
    logic       oTglSw0, oTglSw1, oTglSw2, oTglSw3, oClrSwTgl;
    logic       oReqWatchRpt, oReqSr04Rpt, oReqTempRpt, oReqHumRpt;
    logic [7:0] oLoopData;
    logic       oLoopValid;

    int n_tests;
    int n_failed;

    // Expected outputs: {pulse[13:0], loop_valid, loop_data[7:0]}
    logic [22:0] exp_q[$];

    // Reference command table, ordered MSB-first like the pulse vector
    logic [7:0] cmd_tbl [14];
    logic [7:0] model_loop_data;

    uart_ascii_decoder dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iRxData      (iRxData),
        .iRxValid     (iRxValid),
        .oBtnC        (oBtnC),
        .oBtnU        (oBtnU),
        .oBtnD        (oBtnD),
        .oBtnL        (oBtnL),
        .oBtnR        (oBtnR),
        .oTglSw0      (oTglSw0),
        .oTglSw1      (oTglSw1),
        .oTglSw2      (oTglSw2),
        .oTglSw3      (oTglSw3),
        .oClrSwTgl    (oClrSwTgl),
        .oReqWatchRpt (oReqWatchRpt),
        .oReqSr04Rpt  (oReqSr04Rpt),
        .oReqTempRpt  (oReqTempRpt),
        .oReqHumRpt   (oReqHumRpt),
        .oLoopData    (oLoopData),
        .oLoopValid   (oLoopValid)
    );

    // Clock
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [13:0] obs_pulse();
        return {oBtnC, oBtnU, oBtnD, oBtnL, oBtnR,
                oTglSw0, oTglSw1, oTglSw2, oTglSw3, oClrSwTgl,
                oReqWatchRpt, oReqSr04Rpt, oReqTempRpt, oReqHumRpt};
    endfunction

    // Reference: look the byte up in the table; a hit sets that one bit
    function automatic logic [13:0] model_pulse(input logic valid, input logic [7:0] d);
        logic [13:0] v;
        v = '0;
        if (valid) begin
            for (int i = 0; i < 14; i++) begin
                if (cmd_tbl[i] == d) v = 14'(1) << (13 - i);
            end
        end
        return v;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of input, record the expectation, check after the edge
    task automatic drive_step(input logic valid, input logic [7:0] data);
        logic [22:0] e;
        @(negedge iClk);
        iRxValid = valid;
        iRxData  = data;
        if (valid) model_loop_data = data;
        exp_q.push_back({model_pulse(valid, data), valid, model_loop_data});
        @(posedge iClk);
        #1;
        e = exp_q.pop_front();
        check_val("pulse_vec",  32'(obs_pulse()), 32'(e[22:9]));
        check_val("loop_valid", 32'(oLoopValid),  32'(e[8]));
        check_val("loop_data",  32'(oLoopData),   32'(e[7:0]));
    endtask

    task automatic check_all_clear(input string tag);
        check_val({tag, "_pulse"}, 32'(obs_pulse()), 32'd0);
        check_val({tag, "_lv"},    32'(oLoopValid),  32'd0);
        check_val({tag, "_ld"},    32'(oLoopData),   32'd0);
    endtask

    logic [7:0] misc_tbl [4];

    initial begin
        n_tests  = 0;
        n_failed = 0;
        cmd_tbl = '{8'h63, 8'h75, 8'h64, 8'h6C, 8'h72,
                    8'h31, 8'h33, 8'h35, 8'h36, 8'h78,
                    8'h77, 8'h73, 8'h74, 8'h68};
        misc_tbl = '{8'h43, 8'h0D, 8'h00, 8'hFF};
        model_loop_data = 8'h00;

        // Reset held for 4 clocks
        iRst     = 1'b0;
        iRxValid = 1'b0;
        iRxData  = 8'h00;
        repeat (4) @(posedge iClk);
        #1;
        check_all_clear("reset");
        @(negedge iClk);
        iRst = 1'b1;

        // Every command, valid held 2 clocks, then an idle clock
        for (int i = 0; i < 14; i++) begin
            drive_step(1'b1, cmd_tbl[i]);
            drive_step(1'b1, cmd_tbl[i]);
            drive_step(1'b0, 8'hA5);
        end

        // Non-command bytes: echoed, no pulse
        for (int i = 0; i < 4; i++) begin
            drive_step(1'b1, misc_tbl[i]);
            drive_step(1'b0, 8'h63);
        end

        // Randomized stream: mix of commands and arbitrary bytes
        for (int i = 0; i < 400; i++) begin
            logic       v;
            logic [7:0] d;
            v = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 0) d = cmd_tbl[$urandom_range(0, 13)];
            else                           d = 8'($urandom_range(0, 255));
            drive_step(v, d);
        end

        // Asynchronous reset in the middle of a pulse
        drive_step(1'b1, 8'h63);
        #2;
        iRst = 1'b0;
        #1;
        check_all_clear("async_rst");
        model_loop_data = 8'h00;
        @(negedge iClk);
        iRxValid = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
        // First edge after release decodes normally
        drive_step(1'b1, 8'h75);
        drive_step(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
